// File: rtl/apb_slave_regs_if.sv
// APB3 bus signals between a master and the register-file completer.
// Clock and reset stay outside so the same bundle can be reused on any APB clock domain.
interface apb_slave_regs_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regs.sv
// APB3 completer: NUM_REGS RW words, an ID word and a transfer counter; WAIT_STATES+1 access cycles.
// The master is held with pready low during wait states; dropping psel aborts without side effects.
module apb_slave_regs #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic            pclk,
    input  logic            preset_n,
    apb_slave_regs_if.slave apb,
    output logic [31:0]     ctrl_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [5:0] ID_IDX  = 6'(NUM_REGS);
    localparam logic [5:0] CNT_IDX = 6'(NUM_REGS + 1);
    localparam logic [3:0] WS      = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] xfer_cnt_q, xfer_cnt_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] prdata_q, prdata_d;

    // Misaligned, unmapped, or a write into the read-only words.
    function automatic logic addr_err(input logic [7:0] a, input logic wr);
        logic [5:0] w;
        w = a[7:2];
        if (a[1:0] != 2'b00)                return 1'b1;
        if (w < ID_IDX)                     return 1'b0;
        if ((w == ID_IDX) || (w == CNT_IDX)) return wr;
        return 1'b1;
    endfunction

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            wcnt_q     <= '0;
            xfer_cnt_q <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            wcnt_q     <= wcnt_d;
            xfer_cnt_q <= xfer_cnt_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        wcnt_d     = wcnt_q;
        xfer_cnt_d = xfer_cnt_q;
        regs_d     = regs_q;
        case (state_q)
            S_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    addr_d  = apb.paddr;
                    write_d = apb.pwrite;
                    wdata_d = apb.pwdata;
                    wcnt_d  = WS;
                    state_d = (WS == 4'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!apb.psel) begin
                    state_d = S_IDLE;
                end else if (wcnt_q <= 4'd1) begin
                    state_d = S_DONE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (!apb.psel) begin
                    state_d = S_IDLE;
                end else if (apb.penable) begin
                    state_d    = S_IDLE;
                    xfer_cnt_d = xfer_cnt_q + 32'd1;
                    if (write_q && !addr_err(addr_q, write_q)) begin
                        for (int i = 0; i < int'(NUM_REGS); i++) begin
                            if (addr_q[7:2] == 6'(i)) regs_d[i] = wdata_q;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response is computed one cycle early so pready/pslverr/prdata leave flops.
    always_comb begin
        pready_d  = (state_d == S_DONE);
        pslverr_d = pready_d && addr_err(addr_d, write_d);
        prdata_d  = '0;
        if (pready_d && !pslverr_d && !write_d) begin
            if (addr_d[7:2] == ID_IDX) begin
                prdata_d = ID_VALUE;
            end else if (addr_d[7:2] == CNT_IDX) begin
                prdata_d = xfer_cnt_q;
            end else begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    if (addr_d[7:2] == 6'(i)) prdata_d = regs_q[i];
                end
            end
        end
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;
    assign ctrl_o      = regs_q[0];

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: one instance with zero wait states, one with three.
module tb_apb_slave_regs;

    logic        pclk;
    logic        rst0_n, rst3_n;
    logic        sel3;
    logic        m_psel, m_penable, m_pwrite;
    logic [7:0]  m_paddr;
    logic [31:0] m_pwdata;
    logic [31:0] prdata, ctrl0, ctrl3;
    logic        pready, pslverr;

    int n_checks = 0;
    int n_errors = 0;
    int leak     = 0;
    logic [31:0] cnt0 = 0;
    logic [31:0] cnt3 = 0;

    apb_slave_regs_if bus0 ();
    apb_slave_regs_if bus3 ();

    assign bus0.psel    = m_psel & ~sel3;
    assign bus0.penable = m_penable;
    assign bus0.pwrite  = m_pwrite;
    assign bus0.paddr   = m_paddr;
    assign bus0.pwdata  = m_pwdata;
    assign bus3.psel    = m_psel & sel3;
    assign bus3.penable = m_penable;
    assign bus3.pwrite  = m_pwrite;
    assign bus3.paddr   = m_paddr;
    assign bus3.pwdata  = m_pwdata;

    assign pready  = sel3 ? bus3.pready  : bus0.pready;
    assign pslverr = sel3 ? bus3.pslverr : bus0.pslverr;
    assign prdata  = sel3 ? bus3.prdata  : bus0.prdata;

    apb_slave_regs #(.NUM_REGS(8), .WAIT_STATES(0), .ID_VALUE(32'hA5B0_0001)) dut0 (
        .pclk(pclk), .preset_n(rst0_n), .apb(bus0.slave), .ctrl_o(ctrl0)
    );

    apb_slave_regs #(.NUM_REGS(8), .WAIT_STATES(3), .ID_VALUE(32'hA5B0_0001)) dut3 (
        .pclk(pclk), .preset_n(rst3_n), .apb(bus3.slave), .ctrl_o(ctrl3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Full transfer; address/data are scrambled after setup to confirm they were latched.
    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic err, output int cyc);
        @(posedge pclk); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = a; m_pwdata = d;
        @(posedge pclk); #1;
        m_penable = 1'b1;
        m_paddr   = 8'hFF;
        m_pwdata  = 32'h0BAD_F00D;
        cyc = 1;
        while (!pready && cyc < 40) begin
            if (prdata !== 32'h0) leak++;
            @(posedge pclk); #1;
            cyc++;
        end
        rd  = prdata;
        err = pslverr;
        @(posedge pclk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        if (cyc < 40) begin
            if (sel3) cnt3++;
            else      cnt0++;
        end
    endtask

    logic [31:0] rd;
    logic        err;
    int          cyc;
    int          hits;

    initial begin
        rst0_n = 1'b0; rst3_n = 1'b0; sel3 = 1'b0;
        m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
        repeat (2) @(posedge pclk);
        #1;
        check_eq("rst_pready", {31'b0, pready}, 32'h0);
        check_eq("rst_pslverr", {31'b0, pslverr}, 32'h0);
        check_eq("rst_prdata", prdata, 32'h0);
        check_eq("rst_ctrl", ctrl0, 32'h0);
        rst0_n = 1'b1; rst3_n = 1'b1;

        // Zero-wait instance
        apb_xfer(1'b0, 8'h00, 32'h0, rd, err, cyc);
        check_eq("rd00_data", rd, 32'h0);
        check_eq("rd00_err", {31'b0, err}, 32'h0);
        apb_xfer(1'b0, 8'h24, 32'h0, rd, err, cyc);
        check_eq("rdcnt_data", rd, 32'h1);
        check_eq("rdcnt_err", {31'b0, err}, 32'h0);

        apb_xfer(1'b1, 8'h04, 32'hDEAD_BEEF, rd, err, cyc);
        check_eq("wr04_cycles", cyc, 1);
        check_eq("wr04_err", {31'b0, err}, 32'h0);
        check_eq("ready_drop", {31'b0, pready}, 32'h0);
        apb_xfer(1'b0, 8'h04, 32'h0, rd, err, cyc);
        check_eq("rd04_cycles", cyc, 1);
        check_eq("rd04_data", rd, 32'hDEAD_BEEF);

        apb_xfer(1'b1, 8'h00, 32'h1234_5678, rd, err, cyc);
        check_eq("ctrl_o", ctrl0, 32'h1234_5678);

        apb_xfer(1'b1, 8'h20, 32'h5555_AAAA, rd, err, cyc);
        check_eq("wrid_err", {31'b0, err}, 32'h1);
        check_eq("wrid_data", rd, 32'h0);
        apb_xfer(1'b0, 8'h20, 32'h0, rd, err, cyc);
        check_eq("rdid_data", rd, 32'hA5B0_0001);
        apb_xfer(1'b0, 8'h30, 32'h0, rd, err, cyc);
        check_eq("rd30_err", {31'b0, err}, 32'h1);
        check_eq("rd30_data", rd, 32'h0);
        apb_xfer(1'b1, 8'h06, 32'h0000_0BAD, rd, err, cyc);
        check_eq("wr06_err", {31'b0, err}, 32'h1);
        check_eq("wr06_data", rd, 32'h0);
        apb_xfer(1'b0, 8'h04, 32'h0, rd, err, cyc);
        check_eq("rd04_after_err", rd, 32'hDEAD_BEEF);
        apb_xfer(1'b0, 8'h24, 32'h0, rd, err, cyc);
        check_eq("cnt0_total", rd, cnt0 - 32'd1);

        // Access strobe with no setup phase must not start a transfer
        @(posedge pclk); #1;
        m_psel = 1'b1; m_penable = 1'b1; m_paddr = 8'h00; m_pwrite = 1'b0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk); #1;
            if (pready) hits++;
        end
        m_psel = 1'b0; m_penable = 1'b0;
        check_eq("no_setup_ready", hits, 0);

        // Three-wait instance
        sel3 = 1'b1;
        apb_xfer(1'b0, 8'h20, 32'h0, rd, err, cyc);
        check_eq("ws3_cycles", cyc, 4);
        check_eq("ws3_id", rd, 32'hA5B0_0001);
        apb_xfer(1'b1, 8'h08, 32'h1111_2222, rd, err, cyc);
        check_eq("ws3_wr_cycles", cyc, 4);

        // Abort in the second access cycle
        @(posedge pclk); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 8'h08; m_pwdata = 32'h0000_FFFF;
        @(posedge pclk); #1;
        m_penable = 1'b1;
        hits = pready ? 1 : 0;
        @(posedge pclk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (pready) hits++;
            @(posedge pclk); #1;
        end
        check_eq("abort_ready", hits, 0);
        apb_xfer(1'b0, 8'h08, 32'h0, rd, err, cyc);
        check_eq("abort_rd08", rd, 32'h1111_2222);
        apb_xfer(1'b0, 8'h24, 32'h0, rd, err, cyc);
        check_eq("abort_cnt", rd, 32'h3);

        // Reset while a write is waiting
        apb_xfer(1'b1, 8'h00, 32'h0000_0055, rd, err, cyc);
        apb_xfer(1'b1, 8'h0C, 32'h0000_0077, rd, err, cyc);
        check_eq("ctrl3_set", ctrl3, 32'h0000_0055);
        @(posedge pclk); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 8'h0C; m_pwdata = 32'h0000_0099;
        @(posedge pclk); #1;
        m_penable = 1'b1;
        @(posedge pclk); #1;
        rst3_n = 1'b0;
        #1;
        check_eq("midrst_pready", {31'b0, pready}, 32'h0);
        check_eq("midrst_ctrl", ctrl3, 32'h0);
        m_psel = 1'b0; m_penable = 1'b0;
        cnt3 = 0;
        @(negedge pclk);
        rst3_n = 1'b1;
        apb_xfer(1'b0, 8'h0C, 32'h0, rd, err, cyc);
        check_eq("midrst_rd0c", rd, 32'h0);
        apb_xfer(1'b0, 8'h24, 32'h0, rd, err, cyc);
        check_eq("midrst_cnt", rd, cnt3 - 32'd1);

        check_eq("prdata_while_not_ready", leak, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
